// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer with memory wait-state
// timeout, sticky halt/fault and a retired-instruction counter.
module multicycle_control #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             alu_src_imm,
  output logic             imm_zext,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [1:0]       fault_cause,
  output logic             retired,
  output logic [CNT_W-1:0] instret
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [3:0] OP_ALU_A = 4'd0, OP_ALU_L = 4'd1, OP_LHI = 4'd2, OP_LLI = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4, OP_ANDI = 4'd5, OP_ORI = 4'd6, OP_LD = 4'd7;
  localparam logic [3:0] OP_ST = 4'd8, OP_BEQ = 4'd9, OP_BNE = 4'd10, OP_BLT = 4'd11;
  localparam logic [3:0] OP_BGE = 4'd12, OP_CALL = 4'd13, OP_RET = 4'd14, OP_HALT = 4'd15;
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
    S_WB = 3'd4, S_HALTED = 3'd5, S_FAULT = 3'd6
  } state_t;
  state_t           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] instret_q;
  logic             halted_q, fault_q;
  logic [1:0]       cause_q, cause_d;
  logic             timeout, illegal, is_mem, is_br, uses_imm, zext_op, writes;
  assign timeout  = wait_q == WW'(MAX_WAIT - 1);
  assign illegal  = (opcode == OP_ALU_A && funct3 > 3'd1) || (opcode == OP_ALU_L && funct3 > 3'd5);
  assign is_mem   = opcode == OP_LD || opcode == OP_ST;
  assign is_br    = opcode inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE};
  assign zext_op  = opcode == OP_ANDI || opcode == OP_ORI;
  assign uses_imm = zext_op || is_mem || opcode == OP_ADDI;
  assign writes   = opcode inside {OP_ALU_A, OP_ALU_L, OP_LHI, OP_LLI, OP_ADDI, OP_ANDI, OP_ORI, OP_LD, OP_CALL};
  // The wait counter only runs while a request stays un-acknowledged; any state change clears it.
  assign wait_d = (state_d == state_q && (state_q == S_FETCH || state_q == S_MEM)) ? wait_q + WW'(1) : '0;
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    imem_req    = 1'b0;
    ir_load     = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    alu_src_imm = 1'b0;
    imm_zext    = 1'b0;
    reg_write   = 1'b0;
    wb_sel      = 2'd0;
    pc_en       = 1'b0;
    pc_sel      = 2'd0;
    retired     = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ready;
        state_d  = imem_ready ? S_DECODE : timeout ? S_FAULT : S_FETCH;
        cause_d  = (!imem_ready && timeout) ? 2'd2 : cause_q;
      end
      S_DECODE: begin
        state_d = opcode == OP_HALT ? S_HALTED : illegal ? S_FAULT : S_EXEC;
        cause_d = illegal ? 2'd1 : cause_q;
      end
      S_EXEC: begin
        alu_src_imm = uses_imm;
        imm_zext    = zext_op;
        state_d     = is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req    = 1'b1;
        dmem_we     = opcode == OP_ST;
        alu_src_imm = 1'b1;
        state_d     = dmem_ready ? S_WB : timeout ? S_FAULT : S_MEM;
        cause_d     = (!dmem_ready && timeout) ? 2'd3 : cause_q;
      end
      S_WB: begin
        pc_en     = 1'b1;
        retired   = 1'b1;
        reg_write = writes;
        wb_sel    = opcode == OP_LD ? 2'd1 : (opcode == OP_LHI || opcode == OP_LLI) ? 2'd2 :
                    opcode == OP_CALL ? 2'd3 : 2'd0;
        pc_sel    = is_br ? {1'b0, branch_taken} : opcode == OP_CALL ? 2'd2 :
                    opcode == OP_RET ? 2'd3 : 2'd0;
        state_d   = S_FETCH;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      cause_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= state_q == S_WB ? instret_q + CNT_W'(1) : instret_q;
      halted_q  <= state_d == S_HALTED;
      fault_q   <= state_d == S_FAULT;
      cause_q   <= cause_d;
    end
  end
  assign state       = state_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign instret     = instret_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench; stimulus queues hand-computed expectations,
// a monitor pops them on each retire or halt/fault onset.
module tb_multicycle_control;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic branch_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic imem_req, ir_load, dmem_req, dmem_we, alu_src_imm, imm_zext, reg_write, pc_en;
  logic halted, fault, retired;
  logic [1:0] wb_sel, pc_sel, fault_cause;
  logic [2:0] state;
  logic [15:0] instret;
  logic w_imem_req, w_ir_load, w_dmem_req, w_dmem_we, w_alu_src_imm, w_imm_zext, w_reg_write, w_pc_en;
  logic w_halted, w_fault, w_retired;
  logic [1:0] w_wb_sel, w_pc_sel, w_fault_cause;
  logic [2:0] w_state;
  logic [3:0] w_instret;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_load(ir_load),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .alu_src_imm(alu_src_imm), .imm_zext(imm_zext),
    .reg_write(reg_write), .wb_sel(wb_sel), .pc_en(pc_en), .pc_sel(pc_sel), .state(state),
    .halted(halted), .fault(fault), .fault_cause(fault_cause), .retired(retired), .instret(instret)
  );
  multicycle_control #(.MAX_WAIT(15), .CNT_W(4)) u_w (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(w_imem_req), .ir_load(w_ir_load),
    .dmem_req(w_dmem_req), .dmem_we(w_dmem_we), .alu_src_imm(w_alu_src_imm), .imm_zext(w_imm_zext),
    .reg_write(w_reg_write), .wb_sel(w_wb_sel), .pc_en(w_pc_en), .pc_sel(w_pc_sel), .state(w_state),
    .halted(w_halted), .fault(w_fault), .fault_cause(w_fault_cause), .retired(w_retired), .instret(w_instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op; logic [2:0] f3; logic bt; int iw, dw, lat, ireq, dreq;
    logic term, rw; logic [1:0] wb, pc; logic imm, zext, we; logic [1:0] cause; logic hlt; int ins;
  } vec_t;
  vec_t wq[$], tq[$];
  int checks = 0, failures = 0, n_ret = 0;
  int iw_cfg = 0, dw_cfg = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responders: ready after iw_cfg/dw_cfg un-acknowledged request cycles.
  initial begin
    int ic = 0, dc = 0;
    forever begin
      @(negedge clk);
      imem_ready = !rst && imem_req && ic == iw_cfg;
      dmem_ready = !rst && dmem_req && dc == dw_cfg;
      ic = (!rst && imem_req) ? ic + 1 : 0;
      dc = (!rst && dmem_req) ? dc + 1 : 0;
    end
  end

  // Monitor: accumulates per-instruction observations and pops the scoreboard.
  initial begin
    vec_t e;
    int lat = 0, ireq = 0, dreq = 0;
    logic we_s = 0, ximm = 0, xz = 0, prev_term = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        lat = 0; ireq = 0; dreq = 0; we_s = 0; ximm = 0; xz = 0; prev_term = 0;
      end else if (halted || fault) begin
        if (!prev_term) begin
          if (tq.size() == 0) chk("unexpected_term", 1, 0);
          else begin
            e = tq.pop_front();
            chk("halted", int'(halted), int'(e.hlt));
            chk("fault", int'(fault), int'(!e.hlt));
            chk("fault_cause", int'(fault_cause), int'(e.cause));
            chk("term_latency", lat, e.lat);
            chk("term_imem_req_cycles", ireq, e.ireq);
            chk("term_dmem_req_cycles", dreq, e.dreq);
            chk("term_instret", int'(instret), e.ins);
          end
          lat = 0; ireq = 0; dreq = 0; we_s = 0; ximm = 0; xz = 0;
        end
        chk("term_strobes", int'({imem_req, ir_load, dmem_req, dmem_we, alu_src_imm, imm_zext,
            reg_write, wb_sel, pc_en, pc_sel, retired}), 0);
        prev_term = 1;
      end else begin
        prev_term = 0;
        lat++;
        ireq += int'(imem_req);
        dreq += int'(dmem_req);
        we_s |= dmem_we;
        if (state == 3'd2) begin ximm = alu_src_imm; xz = imm_zext; end
        if (retired) begin
          if (wq.size() == 0) chk("unexpected_retire", 1, 0);
          else begin
            e = wq.pop_front();
            chk("latency", lat, e.lat);
            chk("imem_req_cycles", ireq, e.ireq);
            chk("dmem_req_cycles", dreq, e.dreq);
            chk("dmem_we", int'(we_s), int'(e.we));
            chk("exec_alu_src_imm", int'(ximm), int'(e.imm));
            chk("exec_imm_zext", int'(xz), int'(e.zext));
            chk("reg_write", int'(reg_write), int'(e.rw));
            chk("wb_sel", int'(wb_sel), int'(e.wb));
            chk("pc_sel", int'(pc_sel), int'(e.pc));
            chk("pc_en", int'(pc_en), 1);
            chk("instret", int'(instret), e.ins);
            chk("instret_w4", int'(w_instret), e.ins % 16);
          end
          lat = 0; ireq = 0; dreq = 0; we_s = 0; ximm = 0; xz = 0;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; iw_cfg = 0; dw_cfg = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_ret = 0;
  endtask

  // Called in a FETCH cycle; returns in the next FETCH cycle or on halt/fault onset.
  task automatic run(input vec_t v);
    bit done = 0;
    opcode = v.op; funct3 = v.f3; branch_taken = v.bt; iw_cfg = v.iw; dw_cfg = v.dw;
    v.ins = n_ret;
    if (v.term) tq.push_back(v);
    else begin wq.push_back(v); n_ret++; end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (retired || halted || fault) begin done = 1; break; end
    end
    if (!done) chk("timeout_waiting_for_dut", 0, 1);
    if (retired) begin @(posedge clk); #1; end
  endtask

  task automatic ret(input logic [3:0] op, input logic [2:0] f3, input logic bt, input int iw, input int dw,
                     input int lat, input int ireq, input int dreq, input logic rw, input logic [1:0] wb,
                     input logic [1:0] pc, input logic imm, input logic zext, input logic we);
    vec_t v;
    v = '{op, f3, bt, iw, dw, lat, ireq, dreq, 1'b0, rw, wb, pc, imm, zext, we, 2'd0, 1'b0, 0};
    run(v);
  endtask

  task automatic trm(input logic [3:0] op, input logic [2:0] f3, input int iw, input int dw,
                     input int lat, input int ireq, input int dreq, input logic [1:0] cause, input logic hlt);
    vec_t v;
    v = '{op, f3, 1'b0, iw, dw, lat, ireq, dreq, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, cause, hlt, 0};
    run(v);
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_imem_req", int'(imem_req), 1);
    chk("rst_strobes", int'({dmem_req, dmem_we, alu_src_imm, imm_zext, reg_write, wb_sel, pc_en, pc_sel, retired}), 0);
    chk("rst_instret", int'(instret), 0);
    chk("rst_halted_fault_cause", int'({halted, fault, fault_cause}), 0);
    //  op    f3    bt iw  dw  lat ireq dreq rw wb    pc    imm zx we
    ret(4'd4, 3'd0, 0, 0,  0,  4,  1,   0,   1, 2'd0, 2'd0, 1,  0, 0);
    ret(4'd7, 3'd0, 0, 0,  3,  8,  1,   4,   1, 2'd1, 2'd0, 1,  0, 0);
    ret(4'd8, 3'd0, 0, 0,  3,  8,  1,   4,   0, 2'd0, 2'd0, 1,  0, 1);
    ret(4'd9, 3'd0, 1, 0,  0,  4,  1,   0,   0, 2'd0, 2'd1, 0,  0, 0);
    ret(4'd10,3'd0, 0, 0,  0,  4,  1,   0,   0, 2'd0, 2'd0, 0,  0, 0);
    ret(4'd13,3'd0, 0, 0,  0,  4,  1,   0,   1, 2'd3, 2'd2, 0,  0, 0);
    ret(4'd14,3'd0, 0, 0,  0,  4,  1,   0,   0, 2'd0, 2'd3, 0,  0, 0);
    ret(4'd5, 3'd0, 0, 2,  0,  6,  3,   0,   1, 2'd0, 2'd0, 1,  1, 0);
    ret(4'd6, 3'd0, 0, 0,  0,  4,  1,   0,   1, 2'd0, 2'd0, 1,  1, 0);
    ret(4'd1, 3'd5, 0, 0,  0,  4,  1,   0,   1, 2'd0, 2'd0, 0,  0, 0);
    ret(4'd2, 3'd0, 0, 0,  0,  4,  1,   0,   1, 2'd2, 2'd0, 0,  0, 0);
    ret(4'd0, 3'd1, 0, 0,  0,  4,  1,   0,   1, 2'd0, 2'd0, 0,  0, 0);
    ret(4'd0, 3'd0, 0, 14, 0,  18, 15,  0,   1, 2'd0, 2'd0, 0,  0, 0);
    ret(4'd7, 3'd0, 0, 0,  14, 19, 1,   15,  1, 2'd1, 2'd0, 1,  0, 0);
    ret(4'd11,3'd0, 1, 0,  0,  4,  1,   0,   0, 2'd0, 2'd1, 0,  0, 0);
    ret(4'd3, 3'd7, 0, 0,  0,  4,  1,   0,   1, 2'd2, 2'd0, 0,  0, 0);
    chk("instret_after_16", int'(instret), 16);
    chk("instret_w4_wrapped", int'(w_instret), 0);
    // Reset in the middle of a stalled load.
    opcode = 4'd7; funct3 = 3'd0; iw_cfg = 0; dw_cfg = 255;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (state == 3'd3) break;
    end
    chk("reached_mem", int'(dmem_req), 1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    n_ret = 0; opcode = 4'd4; dw_cfg = 0;
    @(negedge clk);
    chk("rst_mid_mem_state", int'(state), 0);
    chk("rst_mid_mem_dmem_req", int'(dmem_req), 0);
    chk("rst_mid_mem_instret", int'(instret), 0);
    ret(4'd4, 3'd0, 0, 0,  0,  4,  1,   0,   1, 2'd0, 2'd0, 1,  0, 0);
    //  op    f3    iw   dw   lat ireq dreq cause hlt
    do_reset();
    trm(4'd4, 3'd0, 255, 0,   15, 15,  0,   2'd2, 0);
    repeat (3) @(negedge clk);
    do_reset();
    ret(4'd4, 3'd0, 0, 0,  0,  4,  1,   0,   1, 2'd0, 2'd0, 1,  0, 0);
    trm(4'd0, 3'd3, 0,   0,   2,  1,   0,   2'd1, 0);
    repeat (3) @(negedge clk);
    do_reset();
    trm(4'd1, 3'd6, 0,   0,   2,  1,   0,   2'd1, 0);
    repeat (3) @(negedge clk);
    do_reset();
    trm(4'd7, 3'd0, 0,   255, 18, 1,   15,  2'd3, 0);
    repeat (3) @(negedge clk);
    do_reset();
    trm(4'd15,3'd0, 0,   0,   2,  1,   0,   2'd0, 1);
    repeat (20) @(negedge clk);
    chk("scoreboard_drained", wq.size() + tq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multi-cycle successor to the 16-bit CPU's combinational decoder. It sequences every instruction through FETCH/DECODE/EXEC/MEM/WB states and handshakes with instruction and data memory that may insert wait states. It raises a sticky fault on memory timeout or illegal funct3, and counts retired instructions. It sits between the instruction register/datapath and the memories, replacing single-cycle decode in `cpu_top`.

## Interface

Parameters:
- `MAX_WAIT`, default 15: maximum cycles a memory request may stay un-acknowledged before a timeout fault. Must be ≥1.
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `opcode`, input, 4: IR[15:12]. Encodings are the ISA encodings 0000 ALU_A through 1111 HALT.
- `funct3`, input, 3: IR[2:0].
- `branch_taken`, input, 1: datapath compare result for the current branch opcode.
- `imem_ready`, input, 1: instruction memory acknowledge.
- `dmem_ready`, input, 1: data memory acknowledge.
- `imem_req`, output, 1: instruction fetch request.
- `ir_load`, output, 1: latch the instruction word into IR.
- `dmem_req`, output, 1: data memory request.
- `dmem_we`, output, 1: data memory write (ST).
- `alu_src_imm`, output, 1: ALU operand B is imm6.
- `imm_zext`, output, 1: zero-extend imm6 (ANDI, ORI).
- `reg_write`, output, 1: register file write strobe.
- `wb_sel`, output, 2: writeback source. 0 = ALU, 1 = memory, 2 = LI unit, 3 = PC+1.
- `pc_en`, output, 1: PC update strobe.
- `pc_sel`, output, 2: PC source. 0 = PC+1, 1 = branch target, 2 = CALL target, 3 = LR.
- `state`, output, 3: current state encoding, for debug.
- `halted`, output, 1: CPU stopped by HALT.
- `fault`, output, 1: CPU stopped by a fault.
- `fault_cause`, output, 2: 0 = none, 1 = illegal funct3, 2 = imem timeout, 3 = dmem timeout.
- `retired`, output, 1: one-cycle pulse when an instruction commits.
- `instret`, output, CNT_W: retired-instruction count.

## Operation

State encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALTED = 5, FAULT = 6.

Per-state behaviour:
- **FETCH**: `imem_req` = 1.
  - On `imem_ready`: `ir_load` = 1 in the same cycle, then go to DECODE.
  - Otherwise increment the wait counter.
- **DECODE**: operands are read.
  - HALT goes to HALTED.
  - Illegal funct3 goes to FAULT with cause 1. Legal funct3 values are 0–1 for ALU_A and 0–5 for ALU_L.
  - Everything else goes to EXEC.
- **EXEC**:
  - `alu_src_imm` = 1 for ADDI, ANDI, ORI, LD and ST.
  - `imm_zext` = 1 for ANDI and ORI.
  - LD and ST go to MEM. All other opcodes go to WB.
- **MEM**:
  - Signals: `dmem_req` = 1; `dmem_we` = 1 for ST; `alu_src_imm` is held at 1.
  - On `dmem_ready`, go to WB. Otherwise increment the wait counter.
- **WB**: `pc_en` = 1 and `retired` = 1; `instret` increments and wraps at 2^CNT_W.
  - `reg_write` = 1 for ALU_A, ALU_L, LHI, LLI, ADDI, ANDI, ORI, LD and CALL.
  - `wb_sel`: 1 for LD, 2 for LHI/LLI, 3 for CALL, otherwise 0.
  - `pc_sel`: branches use `branch_taken` (1 if taken, else 0); CALL uses 2; RET uses 3; otherwise 0.
  - Next state is FETCH.
- **HALTED** and **FAULT**: terminal. All strobes are 0 and the states persist until `rst`.

Wait counter rules:
- Width is clog2(MAX_WAIT+1).
- Cleared on every entry to FETCH and to MEM.
- In any cycle with ready = 0 and count = MAX_WAIT-1, the next state is FAULT with cause 2 (FETCH) or 3 (MEM).
- Ready asserted in the same cycle wins over the timeout.

Output rules:
- All outputs are decoded from the registered state plus `opcode`/`funct3`. Only `instret`, `halted`, `fault` and `fault_cause` are registered.
- Outputs not listed for a state are 0.
- `halted` and `fault` are mutually exclusive.

## Timing

- Reset: state = FETCH, wait counter = 0, `instret` = 0, `halted` = 0, `fault` = 0, `fault_cause` = 0.
  - FETCH strobes follow combinationally from state, so `imem_req` is 1 in the first cycle after reset.
  - All other strobes are 0 in that cycle.
- Latency with zero wait states:
  - ALU, LI, branch, CALL and RET: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LD and ST: 5 cycles.
  - HALT: `halted` = 1 two cycles after FETCH completes.
  - Each memory wait cycle adds 1 cycle.
- `opcode` and `funct3` must be stable from DECODE through WB. IR is loaded only at the FETCH handshake.
- Memory is an acknowledge-only handshake: `req` stays high until the cycle `ready` = 1, and `req` drops the following cycle. `ready` while `req` = 0 is ignored.
- `rst` wins in any state, including mid-MEM with a pending request: `dmem_req` is 0 in the cycle after `rst` and `instret` is cleared.
- `retired` never asserts in HALTED or FAULT; HALT itself is not counted.

## Test plan

1. Reset, then ADDI with `imem_ready` tied to 1 → `reg_write`, `pc_en` and `retired` assert in cycle 4 after reset release; `alu_src_imm` = 1 in EXEC; `instret` = 1.
2. LD with `dmem_ready` delayed 3 cycles → `dmem_req` high for 4 cycles; WB has `wb_sel` = 1 and `reg_write` = 1; total latency 8 cycles. Repeat with ST: `dmem_we` = 1 in MEM and `reg_write` = 0 in WB.
3. BEQ with `branch_taken` = 1, then BNE with 0 → WB shows `pc_sel` = 1, then 0. CALL → `pc_sel` = 2, `wb_sel` = 3, `reg_write` = 1. RET → `pc_sel` = 3, `reg_write` = 0.
4. `imem_ready` held at 0 with MAX_WAIT = 15 → `fault` = 1 and `fault_cause` = 2 after 15 request cycles; `imem_req` = 0 afterwards. Ready arriving exactly in the 15th cycle → no fault, DECODE entered.
5. ALU_A with funct3 = 3 → FAULT with cause 1 after DECODE and `instret` unchanged. Separately, a HALT opcode → `halted` = 1 and all strobes 0 for the following 20 cycles.
6. Assert `rst` during MEM of a stalled LD → next cycle state = FETCH, `dmem_req` = 0, `instret` = 0. 2^CNT_W retires with CNT_W = 4 → `instret` wraps to 0.
